// File: rtl/memory_reader_if.sv
// Memory read bus between memory_reader and the switch-written 4-entry memory.
//   SEL     : 2-bit entry select, driven by the reader
//   RD_DATA : combinational read data for the entry addressed by SEL
// master = reader side, slave = memory side.
interface memory_reader_if #(
  parameter int unsigned WIDTH = 3
);
  logic [1:0]       SEL;
  logic [WIDTH-1:0] RD_DATA;

  modport master (output SEL, input RD_DATA);
  modport slave  (input SEL, output RD_DATA);
endinterface

// File: rtl/memory_reader.sv
// Sequential read-back sequencer for a 4-entry memory.
// Steps the memory select on a KEY press (MODE=0) or after a dwell of DWELL
// cycles (MODE=1), gives the read one cycle to settle, captures the entry into
// OUT and strobes VALID for one cycle.
// Ports:
//   CLOCK_50 : system clock, rising edge
//   RESET    : synchronous, active-high reset
//   MODE     : 0 = manual step, 1 = auto-scan (static switch level)
//   STEP     : raw active-low KEY, asynchronous
//   mem      : memory read bus (SEL out, RD_DATA in)
//   OUT      : registered captured entry
//   VALID    : one-cycle strobe, high while OUT holds a fresh capture
module memory_reader #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned DWELL = 50_000_000
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET,
  input  logic                  MODE,
  input  logic                  STEP,
  memory_reader_if.master       mem,
  output logic [WIDTH-1:0]      OUT,
  output logic                  VALID
);

  localparam int unsigned CntW = $clog2(DWELL);
  localparam logic [CntW-1:0] CntLast = CntW'(DWELL - 1);

  localparam logic [1:0] StWait    = 2'd0;
  localparam logic [1:0] StSettle  = 2'd1;
  localparam logic [1:0] StCapture = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             valid_q, valid_d;
  logic [2:0]       sync_q;          // {s3, s2, s1}
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             press;
  logic             advance;

  // Falling edge of the synchronised button: one cycle per press.
  assign press = sync_q[2] & ~sync_q[1];

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    out_d   = out_q;
    cnt_d   = '0;
    advance = 1'b0;
    unique case (state_q)
      StWait: begin
        if (MODE) begin
          advance = (cnt_q == CntLast);
          cnt_d   = advance ? '0 : cnt_q + CntW'(1);
        end else begin
          advance = press;
        end
        if (advance) begin
          sel_d   = sel_q + 2'd1;
          state_d = StSettle;
        end
      end
      StSettle: begin
        out_d   = mem.RD_DATA;
        state_d = StCapture;
      end
      StCapture: state_d = StWait;
      default:   state_d = StWait;
    endcase
    valid_d = (state_d == StCapture);
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      // Start in SETTLE so entry 0 is captured without a press.
      state_q <= StSettle;
      sel_q   <= 2'd0;
      out_q   <= '0;
      valid_q <= 1'b0;
      sync_q  <= 3'b111;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      sync_q  <= {sync_q[1:0], STEP};
      cnt_q   <= cnt_d;
    end
  end

  assign mem.SEL = sel_q;
  assign OUT     = out_q;
  assign VALID   = valid_q;

endmodule
